// File: rtl/arm_idecoder_if.sv
// ----------------------------------------------------------------------------
// arm_idecoder_if : fetch-to-decode bus for the ARM32 instruction decoder.
// The master side (fetch) drives the instruction word. The slave side (the
// decoder) returns the registered field slices and the internal opcode.
// ----------------------------------------------------------------------------
interface arm_idecoder_if;
   logic [31:0] instr;      // instruction word
   logic [3:0]  cond;       // instr[31:28]
   logic [6:0]  opcode;     // internal opcode
   logic        en_status;  // instr[20], S bit (L bit for load/store)
   logic [3:0]  rn;         // instr[19:16]
   logic [3:0]  rd;         // instr[15:12]
   logic [3:0]  rs;         // instr[11:8]
   logic [3:0]  rm;         // instr[3:0]
   logic [1:0]  shift_op;   // instr[6:5]
   logic [4:0]  imm5;       // instr[11:7]
   logic [11:0] imm12;      // instr[11:0]
   logic [23:0] imm24;      // instr[23:0]
   logic        P;          // instr[24]
   logic        U;          // instr[23]
   logic        W;          // instr[21]

   modport master (
      output instr,
      input  cond, opcode, en_status, rn, rd, rs, rm,
      input  shift_op, imm5, imm12, imm24, P, U, W
   );

   modport slave (
      input  instr,
      output cond, opcode, en_status, rn, rd, rs, rm,
      output shift_op, imm5, imm12, imm24, P, U, W
   );
endinterface : arm_idecoder_if

// File: rtl/arm_idecoder.sv
// ----------------------------------------------------------------------------
// arm_idecoder : one-stage ARM32 instruction decoder.
// It slices the fixed instruction fields and classifies the instruction into
// a 7-bit internal opcode (data-processing, load/store, branch, NOP, HALT).
// All outputs are registered, so results lag the instruction by one clk edge.
// rst is asynchronous and active-high and clears every output (opcode 0 = NOP).
// Optional build macro IDEC_BRANCH_EN: decode B/BL. When the macro is not
// defined, branch encodings decode to NOP. Field outputs are the same either way.
// ----------------------------------------------------------------------------
module arm_idecoder (
   input  logic           clk,
   input  logic           rst,
   arm_idecoder_if.slave  bus
);

   localparam logic [6:0] OP_NOP  = 7'b000_0000;
   localparam logic [6:0] OP_HALT = 7'b000_0001;
`ifdef IDEC_BRANCH_EN
   localparam logic [6:0] OP_B    = 7'b100_0000;
   localparam logic [6:0] OP_BL   = 7'b100_0001;
`endif

   // Field slices need only instr[31:28] and instr[24:0]. The class bits
   // instr[27:25] feed the opcode decode and are never output directly.
   logic [3:0]  cond_q;
   logic [24:0] field_q;
   logic [6:0]  opcode_d, opcode_q;

   logic [2:0]  alu_code;
   logic        alu_ok;
   logic [2:0]  ls_type;

   // Map the data-processing op field instr[24:21] to the 3-bit ALU selector.
   always_comb begin
      // NOTE: assign a default to every signal first so no path leaves one
      // unassigned. An unassigned path would infer a latch.
      alu_code = 3'b000;
      alu_ok   = 1'b1;
      case (bus.instr[24:21])
         4'b0100: alu_code = 3'b000;  // ADD
         4'b0010: alu_code = 3'b001;  // SUB
         4'b1010: alu_code = 3'b010;  // CMP
         4'b0000: alu_code = 3'b011;  // AND
         4'b1100: alu_code = 3'b100;  // ORR
         4'b0001: alu_code = 3'b101;  // EOR
         4'b1101: alu_code = 3'b110;  // MOV
         4'b1111: alu_code = 3'b111;  // MVN
         default: alu_ok   = 1'b0;    // unsupported ALU op decodes to NOP
      endcase
   end

   // Pick the load/store sub-type from the L bit, the register-offset bit and rn.
   always_comb begin
      ls_type = 3'b110;
      if (bus.instr[20]) begin
         if (bus.instr[25])                ls_type = 3'b101;  // LDR register
         else if (bus.instr[19:16] == 4'hF) ls_type = 3'b001; // literal (PC-relative)
         else                               ls_type = 3'b100; // LDR immediate
      end else begin
         ls_type = bus.instr[25] ? 3'b111 : 3'b110;           // STR reg / imm
      end
   end

   // Decode the opcode by priority. The first matching class wins.
   always_comb begin
      opcode_d = OP_NOP;
      if (bus.instr[27:20] == 8'b0011_0010) begin
         opcode_d = OP_NOP;
      end else if (bus.instr[27:20] == 8'b0001_0000) begin
         opcode_d = OP_HALT;
      end else if (bus.instr[27:25] == 3'b101) begin
`ifdef IDEC_BRANCH_EN
         opcode_d = bus.instr[24] ? OP_BL : OP_B;
`else
         opcode_d = OP_NOP;
`endif
      end else if (bus.instr[27:26] == 2'b01) begin
         opcode_d = {1'b1, ls_type, bus.instr[24], bus.instr[23], bus.instr[21]};
      end else if (bus.instr[27:26] == 2'b00 && alu_ok) begin
         if (bus.instr[25])
            opcode_d = {3'b000, 1'b1, alu_code};   // immediate operand
         else if (!bus.instr[4])
            opcode_d = {3'b001, 1'b1, alu_code};   // register / imm-shift
         else if (!bus.instr[7])
            opcode_d = {3'b011, 1'b1, alu_code};   // register-shifted-register
         else
            opcode_d = OP_NOP;                     // multiply/extension space
      end
   end

   // Pipeline register. An asynchronous clear drives every output to zero.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values. This avoids simulation races.
      if (rst) begin
         cond_q   <= '0;
         field_q  <= '0;
         opcode_q <= OP_NOP;
      end else begin
         cond_q   <= bus.instr[31:28];
         field_q  <= bus.instr[24:0];
         opcode_q <= opcode_d;
      end
   end

   assign bus.cond      = cond_q;
   assign bus.opcode    = opcode_q;
   assign bus.en_status = field_q[20];
   assign bus.rn        = field_q[19:16];
   assign bus.rd        = field_q[15:12];
   assign bus.rs        = field_q[11:8];
   assign bus.rm        = field_q[3:0];
   assign bus.shift_op  = field_q[6:5];
   assign bus.imm5      = field_q[11:7];
   assign bus.imm12     = field_q[11:0];
   assign bus.imm24     = field_q[23:0];
   assign bus.P         = field_q[24];
   assign bus.U         = field_q[23];
   assign bus.W         = field_q[21];

endmodule : arm_idecoder

// File: tb/tb_arm_idecoder.sv
// ----------------------------------------------------------------------------
// tb_arm_idecoder : self-checking bench for arm_idecoder.
// Directed vectors plus biased random instructions, compared against a
// reference decoder built from the instruction-class rules.
// Define IDEC_BRANCH_EN for both the bench and the RTL to cover the branch build.
// ----------------------------------------------------------------------------
module tb_arm_idecoder;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   arm_idecoder_if bus ();

   arm_idecoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef IDEC_BRANCH_EN
   localparam logic [6:0] EXP_B  = 7'b100_0000;
   localparam logic [6:0] EXP_BL = 7'b100_0001;
`else
   localparam logic [6:0] EXP_B  = 7'b000_0000;
   localparam logic [6:0] EXP_BL = 7'b000_0000;
`endif

   // Supported ALU ops, listed in the order of their 3-bit selector.
   localparam logic [3:0] ALU_OPS [8] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000,
                                          4'b1100, 4'b0001, 4'b1101, 4'b1111};

   function automatic int alu_index(input logic [3:0] op);
      for (int k = 0; k < 8; k++)
         if (ALU_OPS[k] == op) return k;
      return -1;
   endfunction

   // Reference opcode, built from the class rules with plain arithmetic.
   function automatic logic [6:0] ref_opcode(input logic [31:0] i);
      int a, t, f;
      if (i[27:20] == 8'h32) return 7'd0;
      if (i[27:20] == 8'h10) return 7'd1;
      if (i[27:25] == 3'b101) return i[24] ? EXP_BL : EXP_B;
      if (i[27:26] == 2'b01) begin
         if (i[20] && !i[25] && i[19:16] == 4'hF) t = 1;
         else t = 4 + (i[20] ? 0 : 2) + (i[25] ? 1 : 0);
         return 7'(64 + t * 8 + int'(i[24]) * 4 + int'(i[23]) * 2 + int'(i[21]));
      end
      if (i[27:26] == 2'b00) begin
         a = alu_index(i[24:21]);
         if (a < 0) return 7'd0;
         if (i[25])     f = 0;
         else if (!i[4]) f = 1;
         else if (!i[7]) f = 3;
         else return 7'd0;
         return 7'(f * 16 + 8 + a);
      end
      return 7'd0;
   endfunction

   function automatic logic [73:0] ref_all(input logic [31:0] i);
      return {i[31:28], ref_opcode(i), i[20], i[19:16], i[15:12], i[11:8], i[3:0],
              i[6:5], i[11:7], i[11:0], i[23:0], i[24], i[23], i[21]};
   endfunction

   function automatic logic [73:0] obs_all();
      return {bus.cond, bus.opcode, bus.en_status, bus.rn, bus.rd, bus.rs, bus.rm,
              bus.shift_op, bus.imm5, bus.imm12, bus.imm24, bus.P, bus.U, bus.W};
   endfunction

   task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one instruction, then sample 1 time unit after the capturing edge.
   task automatic apply(input logic [31:0] v);
      bus.instr = v;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  opcode;
   } vec_t;

   vec_t dir [12];
   logic [31:0] r;
   logic [7:0]  cls;

   initial begin
      dir[0]  = '{32'h0320_0000, 7'b000_0000};
      dir[1]  = '{32'h0100_0000, 7'b000_0001};
      dir[2]  = '{32'h029F_7E50, 7'b000_1000};
      dir[3]  = '{32'h009F_7E28, 7'b001_1000};
      dir[4]  = '{32'h009F_7E38, 7'b011_1000};
      dir[5]  = '{32'hE5BF_0000, 7'b100_1111};
      dir[6]  = '{32'hE530_0000, 7'b110_0101};
      dir[7]  = '{32'hE691_0000, 7'b110_1010};
      dir[8]  = '{32'hE50A_0000, 7'b111_0100};
      dir[9]  = '{32'hE6AA_0000, 7'b111_1011};
      dir[10] = '{32'h8AC5_AACC, EXP_B};
      dir[11] = '{32'h8BC5_AACC, EXP_BL};

      // Reset holds every output at zero across clock edges.
      rst       = 1'b1;
      bus.instr = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", obs_all(), '0);

      // Release with HALT presented. Outputs stay zero until the next edge.
      bus.instr = 32'h0100_0000;
      rst       = 1'b0;
      #1;
      check("post_release_pre_edge", obs_all(), '0);
      @(posedge clk);
      #1;
      check("release_halt_opcode", 74'(bus.opcode), 74'(7'b000_0001));

      // Field-slice vector, with expected values written out explicitly.
      apply(32'h5155_5555);
      check("fields_0x51555555", obs_all(),
            {4'b0101, 7'b011_1010, 1'b1, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
             2'b10, 5'b01010, 12'h555, 24'h55_5555, 1'b1, 1'b0, 1'b0});

      // Directed opcode vectors: NOP/HALT, data-processing, load/store, branch.
      foreach (dir[k]) begin
         apply(dir[k].instr);
         check($sformatf("opcode_%h", dir[k].instr), 74'(bus.opcode), 74'(dir[k].opcode));
         check($sformatf("model_%h", dir[k].instr), obs_all(), ref_all(dir[k].instr));
      end

      // Back-to-back: each result lags its instruction by exactly one edge.
      apply(32'h009F_7E28);
      check("b2b_0", 74'(bus.opcode), 74'(7'b001_1000));
      bus.instr = 32'hE530_0000;
      #2;
      check("b2b_lag_1", 74'(bus.opcode), 74'(7'b001_1000));
      @(posedge clk);
      #1;
      check("b2b_1", 74'(bus.opcode), 74'(7'b110_0101));
      bus.instr = 32'h0320_0000;
      #2;
      check("b2b_lag_2", 74'(bus.opcode), 74'(7'b110_0101));
      @(posedge clk);
      #1;
      check("b2b_2", 74'(bus.opcode), 74'(7'b000_0000));

      // Biased random instructions cover every class and some corner bits.
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 5))
            0:       cls = 8'h32;
            1:       cls = 8'h10;
            2:       cls = {3'b101, 5'($urandom)};
            3:       cls = {2'b01, 6'($urandom)};
            4:       cls = {2'b00, 6'($urandom)};
            default: cls = 8'($urandom);
         endcase
         r[27:20] = cls;
         if ($urandom_range(0, 3) == 0) r[19:16] = 4'hF;
         apply(r);
         check($sformatf("rand_%h", r), obs_all(), ref_all(r));
      end

      // Mid-stream async reset: outputs clear with no clock edge in between.
      apply(32'h5155_5555);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_no_edge", obs_all(), '0);
      @(posedge clk);
      #1;
      check("async_reset_hold", obs_all(), '0);
      bus.instr = 32'h0100_0000;
      rst       = 1'b0;
      #1;
      check("rerelease_pre_edge", obs_all(), '0);
      @(posedge clk);
      #1;
      check("rerelease_halt", obs_all(), ref_all(32'h0100_0000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_arm_idecoder

// File: doc/arm_idecoder.md
Name: arm_idecoder

Overview:
- Instruction decoder for the ARM32 CPU pipeline, sitting between fetch and register-read/execute.
- Splits a 32-bit ARM instruction into its fixed fields: condition, registers, shift, immediates and P/U/W.
- Produces a 7-bit internal opcode that classifies the instruction as data-processing, load/store, branch, NOP or HALT.
- Outputs are registered, so decode costs one pipeline stage.

Parameters:
- None.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  instruction word.
- cond  out  4  instr[31:28].
- opcode  out  7  internal opcode (encoding in Behaviour).
- en_status  out  1  instr[20] (S bit; L bit for load/store).
- rn  out  4  instr[19:16].
- rd  out  4  instr[15:12].
- rs  out  4  instr[11:8].
- rm  out  4  instr[3:0].
- shift_op  out  2  instr[6:5].
- imm5  out  5  instr[11:7].
- imm12  out  12  instr[11:0].
- imm24  out  24  instr[23:0].
- P  out  1  instr[24].
- U  out  1  instr[23].
- W  out  1  instr[21].
- Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Registering and reset:
  - All outputs are registered; values reflect the instr sampled at the previous rising clk edge (latency 1 cycle).
  - No handshake; a new instr is accepted every cycle.
  - rst asserted forces every output to 0 immediately, independent of clk; opcode 0000000 is NOP.
  - Outputs hold 0 until the first clk edge after rst deasserts.
- Field outputs are raw bit slices, always driven regardless of instruction class.
- Opcode is decoded with the following priority; first match wins:
  1. instr[27:20]=00110010 -> NOP, 0000000.
  2. instr[27:20]=00010000 -> HALT, 0000001.
  3. Branch, instr[27:25]=101 -> see Optional Feature.
  4. Load/store, instr[27:26]=01. opcode = {1, t[2:0], P, U, W}, where:
     - literal (L=instr[20]=1, instr[25]=0, rn=1111): t=001.
     - LDR immediate (L=1, instr[25]=0): t=100.
     - LDR register (L=1, instr[25]=1): t=101.
     - STR immediate (L=0, instr[25]=0): t=110.
     - STR register (L=0, instr[25]=1): t=111.
  5. Data-processing, instr[27:26]=00. opcode = {0, f[1:0], 1, a[2:0]}.
     - f selects the operand form:
       - f=00: immediate, instr[25]=1.
       - f=01: register/imm-shift, instr[25]=0 and instr[4]=0.
       - f=11: register-shifted-register, instr[25]=0, instr[4]=1, instr[7]=0.
       - instr[25]=0 with instr[4]=1 and instr[7]=1 -> NOP.
     - a is taken from instr[24:21]:
       - ADD 0100 -> 000; SUB 0010 -> 001; CMP 1010 -> 010; AND 0000 -> 011.
       - ORR 1100 -> 100; EOR 0001 -> 101; MOV 1101 -> 110; MVN 1111 -> 111.
       - Any other ALU op -> NOP.
  6. Anything else -> NOP.
- cond is not evaluated here; conditional execution is handled downstream.

Optional Feature:
- Macro: IDEC_BRANCH_EN.
- Defined: instr[27:25]=101 decodes to B=1000000 when instr[24]=0 and BL=1000001 when instr[24]=1.
- Undefined: branch encodings decode to NOP (0000000).
- Field outputs are identical in both builds.

Test Plan:
- Reset: assert rst mid-stream, no clk edge -> all outputs 0 immediately.
  - Release rst with instr=0x01000000 -> opcode 0000001 after one edge.
- instr=0x51555555 -> after one edge:
  - cond=0101, opcode=0111010, en_status=1, rn=rd=rs=rm=0101.
  - shift_op=10, imm5=01010, imm12=0x555, imm24=0x555555, P=1, U=0, W=0.
- NOP/HALT/data: instr=0x03200000 -> opcode 0000000; 0x01000000 -> 0000001.
  - ADD immediate 0x029F7E50 -> 0001000.
  - ADD register 0x009F7E28 -> 0011000.
  - ADD register-shifted 0x009F7E38 -> 0111000.
- Load/store:
  - 0xE5BF0000 -> 1001111.
  - 0xE5300000 -> 1100101.
  - 0xE6910000 -> 1101010.
  - 0xE50A0000 -> 1110100.
  - 0xE6AA0000 -> 1111011.
- Branch, 0x8AC5AACC:
  - With IDEC_BRANCH_EN -> opcode 1000000; 0x8BC5AACC -> 1000001.
  - Without the macro -> 0000000 for both.
- Back-to-back: change instr every cycle across 0x009F7E28, 0xE5300000, 0x03200000 -> opcodes 0011000, 1100101, 0000000 on consecutive cycles, each lagging instr by exactly one edge.
